// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types and helpers for the fetch aligner.
package ibex_pkg;

  typedef enum logic [1:0] {
    ALN_ALIGNED,
    ALN_SKIP,
    ALN_HALF,
    ALN_ERR
  } aligner_state_e;

  localparam logic [1:0] OPC_FULL = 2'b11;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != OPC_FULL;
  endfunction

endpackage

// File: rtl/ibex_fetch_aligner.sv
// ibex_fetch_aligner: turns word-aligned fetch words into one aligned 16/32-bit instruction per handshake.
module ibex_fetch_aligner
  import ibex_pkg::*;
#(
  parameter logic [31:0] BootAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_addr_i,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_is_compressed_o,
  output logic [31:0] out_addr_o,
  output logic        out_err_o,
  output logic        out_err_plus2_o
);

  aligner_state_e r_state;
  logic [15:0]    r_res;
  logic           r_res_err;
  logic [31:0]    r_pc;

  logic        w_valid;
  logic        w_fready;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_plus2;
  logic        w_use_word;
  logic        w_is_c;
  logic        w_out_hs;
  logic        w_unused;

  assign w_unused = flush_addr_i[0];

  always_comb begin
    w_valid    = 1'b0;
    w_fready   = 1'b0;
    w_instr    = fetch_rdata_i;
    w_err      = fetch_err_i;
    w_plus2    = 1'b0;
    w_use_word = 1'b0;
    unique case (r_state)
      ALN_ALIGNED: begin
        w_valid    = fetch_valid_i;
        w_instr    = is_compressed(fetch_rdata_i[15:0]) ? {16'h0, fetch_rdata_i[15:0]} : fetch_rdata_i;
        w_use_word = 1'b1;
      end
      ALN_HALF: begin
        if (is_compressed(r_res)) begin
          w_valid = 1'b1;
          w_instr = {16'h0, r_res};
          w_err   = r_res_err;
        end else begin
          w_valid    = fetch_valid_i;
          w_instr    = {fetch_rdata_i[15:0], r_res};
          w_err      = r_res_err | fetch_err_i;
          w_plus2    = !r_res_err & fetch_err_i;
          w_use_word = 1'b1;
        end
      end
      default: w_fready = fetch_valid_i;
    endcase
    if (w_use_word) w_fready = w_valid & out_ready_i;
    // A redirect kills both handshakes in the same cycle.
    if (flush_i) begin
      w_valid  = 1'b0;
      w_fready = 1'b0;
    end
  end

  assign w_is_c   = is_compressed(w_instr[15:0]);
  assign w_out_hs = w_valid & out_ready_i;

  assign out_valid_o         = rst_ni & w_valid;
  assign fetch_ready_o       = rst_ni & w_fready;
  assign out_instr_o         = rst_ni ? w_instr : 32'h0;
  assign out_is_compressed_o = rst_ni & w_is_c;
  assign out_addr_o          = rst_ni ? r_pc : 32'h0;
  assign out_err_o           = rst_ni & w_err;
  assign out_err_plus2_o     = rst_ni & w_plus2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ALN_ALIGNED;
      r_res     <= 16'h0;
      r_res_err <= 1'b0;
      r_pc      <= BootAddr;
    end else if (flush_i) begin
      r_state   <= flush_addr_i[1] ? ALN_SKIP : ALN_ALIGNED;
      r_res     <= 16'h0;
      r_res_err <= 1'b0;
      r_pc      <= {flush_addr_i[31:1], 1'b0};
    end else begin
      // Whenever a word is taken its upper half becomes the residual.
      if (w_fready && r_state != ALN_ERR) begin
        r_res     <= fetch_rdata_i[31:16];
        r_res_err <= fetch_err_i;
      end
      if (r_state == ALN_SKIP && fetch_valid_i) r_state <= ALN_HALF;
      if (w_out_hs) begin
        r_pc    <= r_pc + (w_is_c ? 32'd2 : 32'd4);
        r_state <= w_err ? ALN_ERR :
                   !w_is_c ? r_state :
                   r_state == ALN_ALIGNED ? ALN_HALF : ALN_ALIGNED;
      end
    end
  end

endmodule
